// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage RV32 core.
// Resolves load-use stalls, branch flushes and EX operand forwarding, and
// owns the pipeline while a multi-cycle mul/div op is in flight. A watchdog
// bounds that wait, and a saturating counter records stalled fetch cycles.
module hazard_unit #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           D_Rs1,
    input  logic [4:0]           D_Rs2,
    input  logic [4:0]           E_Rs1,
    input  logic [4:0]           E_Rs2,
    input  logic [4:0]           E_Rd,
    input  logic [1:0]           E_ResultSrc,
    input  logic                 E_PCSrc,
    input  logic                 E_MulDiv,
    input  logic                 E_MulDivDone,
    input  logic [4:0]           M_Rd,
    input  logic [4:0]           W_Rd,
    input  logic                 M_RegWrite,
    input  logic                 W_RegWrite,
    output logic                 F_Stall,
    output logic                 D_Stall,
    output logic                 D_Flush,
    output logic                 E_Flush,
    output logic                 E_Stall,
    output logic                 M_Flush,
    output logic [1:0]           E_ForwardA,
    output logic [1:0]           E_ForwardB,
    output logic                 E_MulDivStart,
    output logic                 md_timeout,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int WD_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                md_timeout_q, md_timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    logic       lw_stall_s;
    logic       f_stall_s, d_flush_s, e_flush_s, e_stall_s, m_flush_s, start_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // Forward select for one EX source: MEM result beats WB result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (m_we && (m_rd == rs)) begin
                sel = 2'b10;
            end else if (w_we && (w_rd == rs)) begin
                sel = 2'b01;
            end else begin
                sel = 2'b00;
            end
        end
        return sel;
    endfunction

    assign lw_stall_s = (E_ResultSrc == 2'b01) && (E_Rd != 5'd0) &&
                        ((E_Rd == D_Rs1) || (E_Rd == D_Rs2));
    assign fwd_a_s    = fwd_sel(E_Rs1, M_Rd, M_RegWrite, W_Rd, W_RegWrite);
    assign fwd_b_s    = fwd_sel(E_Rs2, M_Rd, M_RegWrite, W_Rd, W_RegWrite);

    // Next-state, watchdog and pipeline-control decode; WAIT masks load-use and branch.
    always_comb begin
        state_d      = state_q;
        wd_cnt_d     = wd_cnt_q;
        md_timeout_d = md_timeout_q;
        start_s      = 1'b0;
        f_stall_s    = 1'b0;
        d_flush_s    = 1'b0;
        e_flush_s    = 1'b0;
        e_stall_s    = 1'b0;
        m_flush_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (E_MulDiv) begin
                    start_s   = 1'b1;
                    f_stall_s = 1'b1;
                    e_stall_s = 1'b1;
                    m_flush_s = 1'b1;
                    wd_cnt_d  = '0;
                    state_d   = WAIT;
                end else begin
                    f_stall_s = lw_stall_s;
                    d_flush_s = E_PCSrc;
                    e_flush_s = lw_stall_s | E_PCSrc;
                end
            end
            WAIT: begin
                if (E_MulDivDone) begin
                    state_d = IDLE;
                end else if (wd_cnt_q == WD_W'(MD_TIMEOUT - 1)) begin
                    md_timeout_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    f_stall_s = 1'b1;
                    e_stall_s = 1'b1;
                    m_flush_s = 1'b1;
                    wd_cnt_d  = wd_cnt_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, watchdog, sticky error flag and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wd_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wd_cnt_q     <= wd_cnt_d;
            md_timeout_q <= md_timeout_d;
            if (f_stall_s && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Controls are forced quiet while reset is held, independent of the clock.
    assign F_Stall       = ~rst & f_stall_s;
    assign D_Stall       = ~rst & f_stall_s;
    assign D_Flush       = ~rst & d_flush_s;
    assign E_Flush       = ~rst & e_flush_s;
    assign E_Stall       = ~rst & e_stall_s;
    assign M_Flush       = ~rst & m_flush_s;
    assign E_MulDivStart = ~rst & start_s;
    assign E_ForwardA    = rst ? 2'b00 : fwd_a_s;
    assign E_ForwardB    = rst ? 2'b00 : fwd_b_s;
    assign md_timeout    = md_timeout_q;
    assign stall_count   = stall_cnt_q;

endmodule
